// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle between the pipeline and the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_if;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] miss_cnt_o;

  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           br_cnt_o, miss_cnt_o
  );

  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit saturating counters: predicts in IF,
// detects mispredictions in EX and keeps branch/miss statistics.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp
);
  localparam int DEPTH = 1 << IDX_W;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic             valid_d  [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [31:0]      target_d [DEPTH];
  logic [1:0]       ctr_d    [DEPTH];
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, pred_taken, mispredict;

  assign if_idx = bp.if_pc_i[IDX_W+1:2];
  assign if_tag = bp.if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = bp.ex_pc_i[IDX_W+1:2];
  assign ex_tag = bp.ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset and above-tag PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.if_pc_i[1:0], bp.if_pc_i[31:IDX_W+TAG_W+2],
                            bp.ex_pc_i[1:0], bp.ex_pc_i[31:IDX_W+TAG_W+2]};

  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign pred_taken = !rst_i && if_hit && ctr_q[if_idx][1];

  assign mispredict = bp.ex_valid_i &&
                      ((bp.ex_taken_i != bp.ex_pred_taken_i) ||
                       (bp.ex_taken_i && bp.ex_pred_taken_i &&
                        (bp.ex_target_i != bp.ex_pred_target_i)));

  assign bp.pred_taken_o  = pred_taken;
  assign bp.pred_target_o = pred_taken ? target_q[if_idx] : bp.if_pc_i + 32'd4;
  assign bp.mispredict_o  = mispredict;
  assign bp.redirect_pc_o = bp.ex_taken_i ? bp.ex_target_i : bp.ex_pc_i + 32'd4;
  assign bp.br_cnt_o      = br_cnt_q;
  assign bp.miss_cnt_o    = miss_cnt_q;

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bp.ex_valid_i) begin
      br_cnt_d = cnt_sat_inc(br_cnt_q);
      if (mispredict) miss_cnt_d = cnt_sat_inc(miss_cnt_q);
      if (ex_hit) begin
        if (bp.ex_taken_i) begin
          ctr_d[ex_idx]    = ctr_inc(ctr_q[ex_idx]);
          target_d[ex_idx] = bp.ex_target_i;
        end else begin
          ctr_d[ex_idx]    = ctr_dec(ctr_q[ex_idx]);
        end
      end else if (bp.ex_taken_i) begin
        // Taken miss allocates, evicting whatever alias held this index.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = bp.ex_target_i;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus queues expectations each
// cycle; a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_W(4), .TAG_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp    (bp)
  );

  typedef enum int {S_PTAKEN, S_PTGT, S_MISP, S_REDIR, S_BR, S_MISS} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input sel_e sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_pred(input logic t, input logic [31:0] tgt, input string name);
    expect_val(S_PTAKEN, {31'd0, t}, {name, "_ptaken"});
    expect_val(S_PTGT, tgt, {name, "_ptgt"});
  endtask

  task automatic expect_ex(input logic m, input logic [31:0] r, input string name);
    expect_val(S_MISP, {31'd0, m}, {name, "_misp"});
    expect_val(S_REDIR, r, {name, "_redir"});
  endtask

  task automatic expect_cnt(input logic [31:0] b, input logic [31:0] m, input string name);
    expect_val(S_BR, b, {name, "_brcnt"});
    expect_val(S_MISS, m, {name, "_misscnt"});
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ifpc, input logic v, input logic [31:0] expc,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    bp.if_pc_i          = ifpc;
    bp.ex_valid_i       = v;
    bp.ex_pc_i          = expc;
    bp.ex_taken_i       = tk;
    bp.ex_target_i      = tgt;
    bp.ex_pred_taken_i  = ptk;
    bp.ex_pred_target_i = ptgt;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(ifpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compare everything queued for the current cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb_q.pop_front();
        case (e.sel)
          S_PTAKEN: act = {31'd0, bp.pred_taken_o};
          S_PTGT:   act = bp.pred_target_o;
          S_MISP:   act = {31'd0, bp.mispredict_o};
          S_REDIR:  act = bp.redirect_pc_o;
          S_BR:     act = bp.br_cnt_o;
          default:  act = bp.miss_cnt_o;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    idle(32'h100);
    cyc();
    expect_pred(1'b0, 32'h104, "in_reset");
    cyc();
    rst = 1'b0;
    idle(32'h100);
    expect_pred(1'b0, 32'h104, "after_reset");
    expect_cnt(32'd0, 32'd0, "after_reset");

    // First taken resolution allocates 0x100 -> 0x200.
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b1, 32'h200, "alloc");
    expect_pred(1'b0, 32'h104, "alloc_same_cycle");
    cyc();
    idle(32'h100);
    expect_pred(1'b1, 32'h200, "alloc_next");
    expect_cnt(32'd1, 32'd1, "alloc_next");

    // Not-taken x3: ctr 10 -> 01 -> 00 -> 00.
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    expect_ex(1'b1, 32'h104, "nt1");
    expect_pred(1'b1, 32'h200, "nt1_nobypass");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b0, 32'h104, "nt2");
    expect_pred(1'b0, 32'h104, "nt2");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b0, 32'h104, "nt3");
    expect_cnt(32'd3, 32'd2, "nt3");
    cyc();
    idle(32'h100);
    expect_pred(1'b0, 32'h104, "nt_done");
    expect_cnt(32'd4, 32'd2, "nt_done");

    // Four taken: ctr 00 -> 01 -> 10 -> 11 -> 11.
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b1, 32'h200, "t1");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b1, 32'h200, "t2");
    expect_pred(1'b0, 32'h104, "t2");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    expect_ex(1'b0, 32'h200, "t3");
    expect_pred(1'b1, 32'h200, "t3");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    expect_ex(1'b0, 32'h200, "t4");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    expect_ex(1'b1, 32'h104, "sat_nt");
    cyc();
    idle(32'h100);
    expect_pred(1'b1, 32'h200, "sat_hold");
    expect_cnt(32'd9, 32'd5, "sat_hold");

    // Alias 0x140 shares index 0 with a different tag and evicts 0x100.
    cyc();
    drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    expect_ex(1'b1, 32'h300, "alias");
    expect_pred(1'b0, 32'h144, "alias_tagmiss");
    cyc();
    idle(32'h100);
    expect_pred(1'b0, 32'h104, "alias_evicted");
    cyc();
    idle(32'h140);
    expect_pred(1'b1, 32'h300, "alias_new");

    // Correct direction, wrong target.
    cyc();
    drive(32'h140, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    expect_ex(1'b1, 32'h200, "realloc");
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h280, 1'b1, 32'h200);
    expect_ex(1'b1, 32'h280, "wrong_tgt");
    expect_pred(1'b1, 32'h200, "wrong_tgt_pre");
    cyc();
    idle(32'h100);
    expect_pred(1'b1, 32'h280, "wrong_tgt_post");
    expect_cnt(32'd12, 32'd8, "wrong_tgt_post");

    // Asynchronous reset mid-run, checked before any further rising edge.
    cyc();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h280, 1'b0, 32'h104);
    #1;
    rst = 1'b1;
    #1;
    expect_pred(1'b0, 32'h104, "midrst");
    expect_cnt(32'd0, 32'd0, "midrst");
    expect_ex(1'b1, 32'h280, "midrst");
    cyc();
    rst = 1'b0;
    idle(32'h100);
    expect_pred(1'b0, 32'h104, "post_rst");
    expect_cnt(32'd0, 32'd0, "post_rst");

    cyc();
    idle(32'h0);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage pipelined RV32I core. It consumes the resolved branch outcome from the execute-stage branch comparator and feeds predictions back to fetch. The block is a direct-mapped, tagged branch target buffer (BTB) with one 2-bit saturating counter per entry. It predicts the next PC in IF, detects mispredictions in EX and drives the flush/redirect request to the pipeline.

## Interface
Parameters:
- IDX_W, default 4: index width; the table holds 2^IDX_W entries.
- TAG_W, default 8: width of the stored PC tag.

Ports:
- clk_i, in, 1: core clock; all state updates on the rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- if_pc_i, in, 32: PC being fetched this cycle.
- pred_taken_o, out, 1: predicted taken for if_pc_i.
- pred_target_o, out, 32: predicted next PC.
- ex_valid_i, in, 1: a B-type branch is resolving in EX this cycle.
- ex_pc_i, in, 32: PC of the resolving branch.
- ex_taken_i, in, 1: actual outcome from the branch comparator's br_sel_o.
- ex_target_i, in, 32: computed branch target (PC + imm).
- ex_pred_taken_i, in, 1: pred_taken_o value carried down the pipeline with this branch.
- ex_pred_target_i, in, 32: pred_target_o value carried down the pipeline with this branch.
- mispredict_o, out, 1: flush IF/ID and redirect fetch.
- redirect_pc_o, out, 32: correct next PC, meaningful when mispredict_o is 1.
- br_cnt_o, out, 32: number of resolved branches.
- miss_cnt_o, out, 32: number of mispredicted branches.

## Operation
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid (1 bit), tag (TAG_W bits), target (32 bits) and ctr (2 bits): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational):
  - hit = valid[idx] && tag[idx] == tag(if_pc_i).
  - pred_taken_o = hit && ctr[idx][1].
  - pred_target_o = pred_taken_o ? target[idx] : if_pc_i + 4, modulo 2^32.
- Mispredict (combinational):
  - mispredict_o = ex_valid_i && (ex_taken_i != ex_pred_taken_i || (ex_taken_i && ex_pred_taken_i && ex_target_i != ex_pred_target_i)).
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 4.
- Update on the clock edge when ex_valid_i = 1, using the ex_pc_i lookup:
  - Hit, taken: ctr increments and saturates at 11; target <= ex_target_i.
  - Hit, not taken: ctr decrements and saturates at 00; target is unchanged.
  - Miss, taken: allocate the entry (overwrite any existing one): valid = 1, tag written, target = ex_target_i, ctr = 10.
  - Miss, not taken: no table change.
- When ex_valid_i = 0, the table and counters hold. The ex_* inputs are don't-care.
- Statistics, when ex_valid_i = 1:
  - br_cnt_o increments by 1.
  - miss_cnt_o increments by 1 when mispredict_o = 1.
  - Both saturate at 32'hFFFFFFFF; they do not wrap.

## Timing
- Reset values: all valid = 0, ctr = 01, target = 0, tag = 0, br_cnt_o = 0, miss_cnt_o = 0.
- While rst_i is high, pred_taken_o = 0 and pred_target_o = if_pc_i + 4. mispredict_o and redirect_pc_o remain combinational from the ex_* inputs.
- Reset asserted mid-operation clears the table immediately, with no clock needed. Any update pending that cycle is lost.
- Prediction latency: 0 cycles (combinational from if_pc_i and registered state).
- Update latency: an update is visible to lookups from the cycle after the ex_valid_i edge.
- If IF and EX address the same index in the same cycle, IF sees the pre-update contents. There is no bypass.
- Mispredict latency: mispredict_o is asserted in the same cycle as ex_valid_i. The pipeline flushes on the following edge.
- Aliasing: a different PC mapping to the same index with a different tag is a miss. If taken, it evicts the entry.

## Test plan
- Reset, then present if_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104; br_cnt_o = miss_cnt_o = 0.
- Resolve ex_pc_i = 0x100, taken, target 0x200, ex_pred_taken_i = 0 -> mispredict_o = 1, redirect_pc_o = 0x200. Next cycle, if_pc_i = 0x100 gives pred_taken_o = 1, pred_target_o = 0x200; miss_cnt_o = 1.
- Same branch resolved not-taken twice (ctr 10 -> 01 -> 00) -> the 1st resolution has mispredict_o = 1 with redirect_pc_o = 0x104. Afterwards pred_taken_o = 0. A 3rd not-taken keeps ctr at 00 with mispredict_o = 0.
- Four consecutive taken resolutions -> ctr saturates at 11. One not-taken then leaves pred_taken_o = 1.
- Alias: allocate 0x100 taken, then resolve 0x140 taken to 0x300 (IDX_W = 4, same index, different tag) -> 0x100 now misses (pred_target_o = 0x104) and 0x140 predicts 0x300.
- Taken with correct direction but wrong target (pred 0x200, actual 0x280) -> mispredict_o = 1, redirect_pc_o = 0x280, stored target becomes 0x280. Assert rst_i mid-run -> pred_taken_o = 0 without a clock, and counters read 0.
